// File: rtl/modn_updown_counter.sv
// Modulo-M up/down counter with a run-time modulus, wrap or saturate mode,
// a terminal-count flag and a registered wrap/saturation event pulse.
module modn_updown_counter #(
   parameter int WIDTH     = 4,
   parameter int N_DEFAULT = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_dn,
   input  logic             sat,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] mod_n,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap_evt,
   output logic [WIDTH-1:0] mod_act
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
   localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

   logic [WIDTH-1:0] mc;
   logic [WIDTH-1:0] mc_max;
   logic [WIDTH-1:0] act_max;
   logic             at_term;
   logic             held;
   logic             held_dir;

   assign mc      = (mod_n < TWO) ? TWO : mod_n;
   assign mc_max  = mc - ONE;
   assign act_max = mod_act - ONE;
   assign at_term = up_dn ? (count == act_max) : (count == '0);
   assign tc      = en & ~load & ~reset & at_term;

   // held/held_dir remember a saturation hit so the event fires once per
   // hold; a direction flip or leaving the terminal re-arms it.
   always_ff @(posedge clk) begin
      if (reset) begin
         count    <= '0;
         mod_act  <= WIDTH'(N_DEFAULT);
         wrap_evt <= 1'b0;
         held     <= 1'b0;
         held_dir <= 1'b0;
      end else if (load) begin
         mod_act  <= mc;
         count    <= (load_val < mc) ? load_val : mc_max;
         wrap_evt <= 1'b0;
         held     <= 1'b0;
      end else if (en) begin
         if (at_term) begin
            mod_act <= mc;
            if (!sat) begin
               count    <= up_dn ? '0 : mc_max;
               wrap_evt <= 1'b1;
               held     <= 1'b0;
            end else begin
               // Keep count inside the newly adopted range.
               if (count > mc_max) count <= mc_max;
               wrap_evt <= ~(held && (held_dir == up_dn));
               held     <= 1'b1;
               held_dir <= up_dn;
            end
         end else begin
            count    <= up_dn ? count + ONE : count - ONE;
            wrap_evt <= 1'b0;
            held     <= 1'b0;
         end
      end else begin
         wrap_evt <= 1'b0;
      end
   end

endmodule

// File: tb/tb_modn_updown_counter.sv
// Self-checking bench for modn_updown_counter: directed test-plan steps
// followed by randomized cycles, all checked against a behavioural model.
module tb_modn_updown_counter;

   logic       clk = 1'b0;
   logic       reset = 1'b0, en = 1'b0, up_dn = 1'b0, sat = 1'b0, load = 1'b0;
   logic [3:0] load_val = '0, mod_n = 4'd10;
   logic [3:0] count, mod_act;
   logic       tc, wrap_evt;

   int n_tests = 0;
   int n_fail  = 0;

   // model state
   int m_cnt = 0, m_mod = 10;
   bit m_evt = 0, m_held = 0, m_hdir = 0;

   modn_updown_counter #(.WIDTH(4), .N_DEFAULT(10)) dut (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .sat(sat),
      .load(load), .load_val(load_val), .mod_n(mod_n), .count(count),
      .tc(tc), .wrap_evt(wrap_evt), .mod_act(mod_act)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input bit e, input bit u, input bit s, input bit l,
                      input int lv, input int mn, input bit r = 1'b0);
      int  mc;
      bit  term;
      @(negedge clk);
      reset = r; en = e; up_dn = u; sat = s; load = l;
      load_val = 4'(lv); mod_n = 4'(mn);
      mc   = (mn < 2) ? 2 : mn;
      term = u ? (m_cnt == m_mod - 1) : (m_cnt == 0);
      #1;
      chk("tc", int'(tc), int'(e && !l && !r && term));
      @(posedge clk);
      if (r) begin
         m_cnt = 0; m_mod = 10; m_evt = 0; m_held = 0;
      end else if (l) begin
         m_mod = mc; m_cnt = (lv > mc - 1) ? mc - 1 : lv; m_evt = 0; m_held = 0;
      end else if (e && term) begin
         m_mod = mc;
         if (!s) begin
            m_cnt = u ? 0 : mc - 1; m_evt = 1; m_held = 0;
         end else begin
            m_evt = !(m_held && m_hdir == u);
            m_held = 1; m_hdir = u;
            if (m_cnt > mc - 1) m_cnt = mc - 1;
         end
      end else if (e) begin
         m_cnt = u ? (m_cnt + 1) % m_mod : (m_cnt + m_mod - 1) % m_mod;
         m_evt = 0; m_held = 0;
      end else begin
         m_evt = 0;
      end
      #1;
      chk("count", int'(count), m_cnt);
      chk("mod_act", int'(mod_act), m_mod);
      chk("wrap_evt", int'(wrap_evt), int'(m_evt));
   endtask

   initial begin
      // reset
      cyc(0, 0, 0, 0, 0, 10, 1);
      chk("rst_count", int'(count), 0);
      chk("rst_mod", int'(mod_act), 10);
      // down wrap 0 -> 9 -> ... -> 0 -> 9
      cyc(1, 0, 0, 0, 0, 10);
      chk("down_wrap_cnt", int'(count), 9);
      chk("down_wrap_evt", int'(wrap_evt), 1);
      repeat (11) cyc(1, 0, 0, 0, 0, 10);
      // up mod 6 from 3
      cyc(0, 1, 0, 1, 3, 6);
      chk("mod6", int'(mod_act), 6);
      repeat (3) cyc(1, 1, 0, 0, 0, 6);
      chk("mod6_wrap", int'(count), 0);
      repeat (3) cyc(1, 1, 0, 0, 0, 6);
      // mid-count modulus change
      cyc(0, 1, 0, 1, 4, 10);
      repeat (6) cyc(1, 1, 0, 0, 0, 5);
      chk("midmod_cnt", int'(count), 0);
      chk("midmod_mod", int'(mod_act), 5);
      repeat (6) cyc(1, 1, 0, 0, 0, 5);
      // saturate down from 2, then flip up
      cyc(0, 0, 1, 1, 2, 10);
      repeat (5) cyc(1, 0, 1, 0, 0, 10);
      chk("sat_hold", int'(count), 0);
      chk("sat_noevt", int'(wrap_evt), 0);
      repeat (3) cyc(1, 1, 1, 0, 0, 10);
      chk("sat_up", int'(count), 3);
      // saturate up, idle, then resume at terminal
      repeat (8) cyc(1, 1, 1, 0, 0, 10);
      cyc(0, 1, 1, 0, 0, 10);
      repeat (2) cyc(1, 1, 1, 0, 0, 10);
      // load clamps
      cyc(0, 0, 0, 1, 12, 7);
      chk("clamp_lv", int'(count), 6);
      cyc(0, 0, 0, 1, 1, 0);
      chk("clamp_mod", int'(mod_act), 2);
      repeat (3) cyc(1, 0, 0, 0, 0, 0);
      chk("toggle", int'(count), 0);
      // priority
      cyc(0, 1, 0, 1, 5, 10);
      cyc(1, 1, 0, 1, 3, 7, 1);
      chk("prio_rst_cnt", int'(count), 0);
      chk("prio_rst_mod", int'(mod_act), 10);
      cyc(1, 0, 0, 1, 7, 10);
      chk("prio_load_cnt", int'(count), 7);
      chk("prio_load_evt", int'(wrap_evt), 0);
      // randomized
      for (int i = 0; i < 600; i++) begin
         cyc($urandom_range(3, 0) != 0, 1'($urandom), $urandom_range(3, 0) == 0,
             $urandom_range(9, 0) == 0, $urandom_range(15, 0),
             ($urandom_range(7, 0) == 0) ? $urandom_range(15, 0) : $urandom_range(7, 3),
             $urandom_range(49, 0) == 0);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
